// File: rtl/memory.sv
// Purpose: M-stage load/store unit; drives one dcache request per access and extends load data.
// Latency: 4 cycles from IDLE to DONE when ready and resp arrive on their first eligible cycle (3 stalled).
// Backpressure: holds M and upstream via memory_o_stall while the request or response is outstanding.
module memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        regM_i_mem_ren,
    input  logic        regM_i_mem_wen,
    input  logic [2:0]  regM_i_func3,
    input  logic [63:0] regM_i_alu_result,
    input  logic [63:0] regM_i_rs2_data,
    output logic        dcache_o_req_valid,
    input  logic        dcache_i_req_ready,
    output logic [63:0] dcache_o_addr,
    output logic        dcache_o_wen,
    output logic [63:0] dcache_o_wdata,
    output logic [7:0]  dcache_o_wstrb,
    input  logic        dcache_i_resp_valid,
    input  logic [63:0] dcache_i_resp_rdata,
    output logic [63:0] memory_o_memdata,
    output logic        memory_o_stall,
    output logic        memory_o_misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] memdata_q, memdata_d;

    logic        access;
    logic        aligned;
    logic [2:0]  off;
    logic [5:0]  bit_sh;
    logic [7:0]  size_mask;
    logic [63:0] ld_field;
    logic [63:0] ld_ext;

    assign access = regM_i_mem_ren | regM_i_mem_wen;
    assign off    = regM_i_alu_result[2:0];
    assign bit_sh = {off, 3'b000};

    // Alignment and byte-enable width both follow func3[1:0] (b/h/w/d); func3[2] only selects zero-extension.
    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (regM_i_func3[1:0])
            2'b00: begin aligned = 1'b1;          size_mask = 8'h01; end
            2'b01: begin aligned = ~off[0];       size_mask = 8'h03; end
            2'b10: begin aligned = (off[1:0] == 2'b00); size_mask = 8'h0F; end
            default: begin aligned = (off == 3'b000); size_mask = 8'hFF; end
        endcase
    end

    // Load data arrives doubleword-aligned; bring the addressed field down to bit 0, then extend.
    assign ld_field = dcache_i_resp_rdata >> bit_sh;

    // Sign- or zero-extend the load field according to func3.
    always_comb begin
        ld_ext = ld_field;
        case (regM_i_func3)
            3'b000:  ld_ext = {{56{ld_field[7]}},  ld_field[7:0]};
            3'b001:  ld_ext = {{48{ld_field[15]}}, ld_field[15:0]};
            3'b010:  ld_ext = {{32{ld_field[31]}}, ld_field[31:0]};
            3'b100:  ld_ext = {56'd0, ld_field[7:0]};
            3'b101:  ld_ext = {48'd0, ld_field[15:0]};
            3'b110:  ld_ext = {32'd0, ld_field[31:0]};
            default: ld_ext = ld_field;
        endcase
    end

    // Request fields come straight from the M register, which the stall keeps frozen while in REQ.
    assign dcache_o_addr      = {regM_i_alu_result[63:3], 3'b000};
    assign dcache_o_wen       = regM_i_mem_wen;
    assign dcache_o_wdata     = regM_i_rs2_data << bit_sh;
    assign dcache_o_wstrb     = size_mask << off;
    assign dcache_o_req_valid = (state_q == S_REQ);

    // Misaligned accesses never start a transaction; the exception path takes over instead.
    assign memory_o_misalign  = access & ~aligned;
    assign memory_o_stall     = ((state_q == S_IDLE) & access & aligned)
                              | (state_q == S_REQ) | (state_q == S_WAIT);
    assign memory_o_memdata   = memdata_q;

    // Next-state logic; ready and resp_valid are only looked at in the state that expects them.
    always_comb begin
        state_d   = state_q;
        memdata_d = memdata_q;
        case (state_q)
            S_IDLE: if (access && aligned) state_d = S_REQ;
            S_REQ:  if (dcache_i_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (dcache_i_resp_valid) begin
                    state_d = S_DONE;
                    if (regM_i_mem_ren) memdata_d = ld_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and load-result registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            memdata_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            memdata_q <= memdata_d;
        end
    end

endmodule
